// File: rtl/bpsk_modem_if.sv
// bpsk_modem_if: transmit handshake and receive decision bundle for bpsk_modem.
//   tx_data/tx_valid  : bit offered by upstream (master -> slave)
//   tx_ready          : 1-deep holding register empty (slave -> master)
//   rx_data/rx_valid  : decided bit and its 1-cycle qualifier (slave -> master)
//   rx_err            : mismatch count of the last receive window (slave -> master)
interface bpsk_modem_if #(
    parameter int unsigned CNT_W = 11
);
    logic             tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             rx_data;
    logic             rx_valid;
    logic [CNT_W-1:0] rx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/bpsk_modem.sv
// bpsk_modem: BPSK/DBPSK modem with square-wave carrier, symbol timer,
// 1-deep handshaked transmit holding register and a correlating
// hard-decision receiver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : bpsk_modem_if.slave (tx_data/tx_valid/tx_ready,
//                 rx_data/rx_valid/rx_err)
//   carrier     : square-wave carrier, CARRIER_DIV clocks per half-period
//   modulated   : line output, carrier xor phase
//   bit_strobe  : pulse on the last cycle of each symbol window
//   rx_in       : received line signal (asynchronous)
// Optional feature: define BPSK_PRBS_EN to fill transmit underruns with a
// PRBS7 sequence (x^7+x^6+1, seed 7'h7F) instead of constant 0.
module bpsk_modem #(
    parameter int unsigned CARRIER_DIV = 120,
    parameter int unsigned BIT_PERIOD  = 1200,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned DIFF        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    bpsk_modem_if.slave      bus,
    output logic             carrier,
    output logic             modulated,
    output logic             bit_strobe,
    input  logic             rx_in
);
    localparam int unsigned C_W = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [C_W-1:0]   C_LAST = C_W'(CARRIER_DIV - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] B_PRE  = CNT_W'(BIT_PERIOD - 2);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(BIT_PERIOD / 2);

    logic [C_W-1:0]   c_cnt;
    logic [CNT_W-1:0] b_cnt;
    logic             hold_bit;
    logic             ready_q;
    logic             phase;
    logic             fill_bit;
    logic             sym;
    logic             xfer;

    logic             rx_m;
    logic             rx_s;
    logic [2:0]       car_d;
    logic [2:0]       first_d;
    logic [2:0]       last_d;
    logic [CNT_W-1:0] err_cnt;
    logic             mism;
    logic [CNT_W-1:0] total;
    logic             hard;
    logic             prev_hard;
    logic             rx_data_q;
    logic             rx_valid_q;
    logic [CNT_W-1:0] rx_err_q;

    assign bus.tx_ready = ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;

    // Carrier divider: toggle on the last count of each half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt   <= '0;
            carrier <= 1'b0;
        end else if (c_cnt == C_LAST) begin
            c_cnt   <= '0;
            carrier <= ~carrier;
        end else begin
            c_cnt   <= c_cnt + C_W'(1);
        end
    end

    // Symbol timer; the strobe is registered one count early so it is high
    // exactly while b_cnt sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt      <= '0;
            bit_strobe <= 1'b0;
        end else begin
            b_cnt      <= (b_cnt == B_LAST) ? '0 : b_cnt + CNT_W'(1);
            bit_strobe <= (b_cnt == B_PRE);
        end
    end

`ifdef BPSK_PRBS_EN
    logic [6:0] lfsr;

    assign fill_bit = lfsr[6];

    // PRBS7 advances only when its bit is consumed as an underrun fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 7'h7F;
        end else if (bit_strobe && ready_q) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
`else
    assign fill_bit = 1'b0;
`endif

    assign xfer = bus.tx_valid & ready_q;
    assign sym  = ready_q ? fill_bit : hold_bit;

    // Holding register: a transfer on a strobe cycle lands in hold, never in
    // the symbol being started, so the load uses the pre-transfer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_bit <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            if (xfer) begin
                hold_bit <= bus.tx_data;
                ready_q  <= 1'b0;
            end else if (bit_strobe) begin
                ready_q  <= 1'b1;
            end
        end
    end

    // Phase update at symbol boundaries and registered modulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            modulated <= 1'b0;
        end else begin
            if (bit_strobe) begin
                phase <= (DIFF != 0) ? (phase ^ sym) : sym;
            end
            modulated <= carrier ^ phase;
        end
    end

    // Receive front end: 2-flop synchroniser plus 3-cycle delayed reference
    // carrier and window markers, which line up exactly with a loopback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b0;
            rx_s    <= 1'b0;
            car_d   <= '0;
            first_d <= '0;
            last_d  <= '0;
        end else begin
            rx_m    <= rx_in;
            rx_s    <= rx_m;
            car_d   <= {car_d[1:0], carrier};
            first_d <= {first_d[1:0], (b_cnt == '0)};
            last_d  <= {last_d[1:0], bit_strobe};
        end
    end

    assign mism  = rx_s ^ car_d[2];
    assign total = err_cnt + CNT_W'(mism);
    assign hard  = (total > HALF);

    // Mismatch accumulation; the first sample of a window reloads the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (first_d[2]) begin
            err_cnt <= CNT_W'(mism);
        end else begin
            err_cnt <= total;
        end
    end

    // Hard decision at the end of each receive window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 1'b0;
            rx_err_q   <= '0;
            prev_hard  <= 1'b0;
        end else begin
            rx_valid_q <= last_d[2];
            if (last_d[2]) begin
                rx_err_q  <= total;
                rx_data_q <= (DIFF != 0) ? (hard ^ prev_hard) : hard;
                prev_hard <= hard;
            end
        end
    end
endmodule

// File: tb/tb_bpsk_modem.sv
// tb_bpsk_modem: directed bench for bpsk_modem with CARRIER_DIV=4,
// BIT_PERIOD=16, CNT_W=5; one absolute-BPSK instance and one DBPSK instance.
`timescale 1ns/1ps
module tb_bpsk_modem;
    localparam int unsigned CW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_data = 1'b0;
    logic loop = 1'b1;
    logic inv = 1'b0;
    logic car_q = 1'b0;

    logic carrier0, modulated0, strobe0, rx_in0;
    logic carrier1, modulated1, strobe1;

    bpsk_modem_if #(.CNT_W(CW)) if0 ();
    bpsk_modem_if #(.CNT_W(CW)) if1 ();

    assign if0.tx_valid = tx_valid & ~sel;
    assign if0.tx_data  = tx_data;
    assign if1.tx_valid = tx_valid & sel;
    assign if1.tx_data  = tx_data;

    // Direct-drive source: a phase-0 line signal built from the carrier,
    // with selected samples inverted.
    always @(posedge clk) car_q <= carrier0;
    assign rx_in0 = loop ? modulated0 : (car_q ^ inv);

    bpsk_modem #(.CARRIER_DIV(4), .BIT_PERIOD(16), .CNT_W(CW), .DIFF(0)) u_bpsk (
        .clk(clk), .rst_n(rst_n), .bus(if0), .carrier(carrier0),
        .modulated(modulated0), .bit_strobe(strobe0), .rx_in(rx_in0)
    );

    bpsk_modem #(.CARRIER_DIV(4), .BIT_PERIOD(16), .CNT_W(CW), .DIFF(1)) u_dbpsk (
        .clk(clk), .rst_n(rst_n), .bus(if1), .carrier(carrier1),
        .modulated(modulated1), .bit_strobe(strobe1), .rx_in(modulated1)
    );

    logic          strobe, ready, rvalid, rdata, car, modl;
    logic [CW-1:0] rerr;
    assign strobe = sel ? strobe1 : strobe0;
    assign ready  = sel ? if1.tx_ready : if0.tx_ready;
    assign rvalid = sel ? if1.rx_valid : if0.rx_valid;
    assign rdata  = sel ? if1.rx_data : if0.rx_data;
    assign rerr   = sel ? if1.rx_err : if0.rx_err;
    assign car    = sel ? carrier1 : carrier0;
    assign modl   = sel ? modulated1 : modulated0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance at least one cycle, stopping on the next strobe cycle.
    task automatic to_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strobe && n < 40);
        if (!strobe) begin
            n_cmp++;
            n_bad++;
            $error("FAIL strobe_timeout: observed no strobe, expected one within 40 cycles");
        end
    endtask

    task automatic send(input logic b);
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(ready), 32'(1));
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_fall", 32'(ready), 32'(0));
    endtask

    // Called on a window-ending strobe cycle; decision is due 4 cycles later.
    task automatic rx_after_strobe(input string tag, input logic d, input logic [CW-1:0] e);
        repeat (3) @(negedge clk);
        check({tag, "_valid_early"}, 32'(rvalid), 32'(0));
        @(negedge clk);
        check({tag, "_valid"}, 32'(rvalid), 32'(1));
        check({tag, "_data"}, 32'(rdata), 32'(d));
        check({tag, "_err"}, 32'(rerr), 32'(e));
    endtask

    // Send one bit and check its decision two strobes later.
    task automatic loop_bit(input string tag, input logic b, input logic d, input logic [CW-1:0] e);
        send(b);
        if (!strobe) to_strobe();
        to_strobe();
        rx_after_strobe(tag, d, e);
    endtask

    // Asynchronous reset mid-cycle, then count to the first strobe.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_carrier"}, 32'(car), 32'(0));
        check({tag, "_modulated"}, 32'(modl), 32'(0));
        check({tag, "_strobe"}, 32'(strobe), 32'(0));
        check({tag, "_rx_data"}, 32'(rdata), 32'(0));
        check({tag, "_rx_valid"}, 32'(rvalid), 32'(0));
        check({tag, "_rx_err"}, 32'(rerr), 32'(0));
        check({tag, "_tx_ready"}, 32'(ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 14) check({tag, "_strobe_c15"}, 32'(strobe), 32'(0));
            if (i == 15) check({tag, "_strobe_c16"}, 32'(strobe), 32'(1));
        end
    endtask

    task automatic noise(input string tag, input int n_inv, input logic d, input logic [CW-1:0] e);
        to_strobe();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            inv = (i < n_inv);
        end
        @(negedge clk);
        inv = 1'b0;
        @(negedge clk);
        check({tag, "_valid_early"}, 32'(rvalid), 32'(0));
        @(negedge clk);
        check({tag, "_valid"}, 32'(rvalid), 32'(1));
        check({tag, "_data"}, 32'(rdata), 32'(d));
        check({tag, "_err"}, 32'(rerr), 32'(e));
    endtask

    initial begin
        logic [7:0] pat;
        logic [6:0] lfsr_m;
        logic       exp_d;
        logic       ready_m;
        int         xfers;

        // Reset values and first strobe after release
        @(negedge clk);
        reset_pulse("rst0");

        // BPSK loopback
        pat = 8'b1011_0010;
        for (int k = 7; k >= 0; k--) begin
            loop_bit("bpsk", pat[k], pat[k], pat[k] ? CW'(16) : CW'(0));
        end

        // Backpressure: tx_valid held for 5 windows
        to_strobe();
        @(negedge clk);
        ready_m  = 1'b1;
        xfers    = 0;
        tx_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tx_data = i[4];
            check("bp_ready", 32'(ready), 32'(ready_m));
            if (ready) xfers++;
            if (ready_m) ready_m = 1'b0;
            else if (i % 16 == 15) ready_m = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("bp_transfers", 32'(xfers), 32'(5));

        // Noise margin with rx_in driven directly
        loop = 1'b0;
        noise("noise7", 7, 1'b0, CW'(7));
        noise("noise8", 8, 1'b0, CW'(8));
        noise("noise9", 9, 1'b1, CW'(9));
        loop = 1'b1;

        // Reset in the middle of operation with hold full
        send(1'b1);
        @(negedge clk);
        reset_pulse("rst_mid");

        // Underrun: no transfers, window 0 carries the reset phase
        lfsr_m = 7'h7F;
        exp_d  = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (w > 0) to_strobe();
            rx_after_strobe("underrun", exp_d, exp_d ? CW'(16) : CW'(0));
`ifdef BPSK_PRBS_EN
            exp_d  = lfsr_m[6];
            lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
`else
            exp_d  = 1'b0;
`endif
        end

        // DBPSK: first bit is transferred on a strobe cycle into hold
        sel = 1'b1;
        reset_pulse("rst_dbpsk");
        loop_bit("dbpsk1", 1'b1, 1'b1, CW'(16));
        loop_bit("dbpsk2", 1'b1, 1'b1, CW'(0));
        loop_bit("dbpsk3", 1'b0, 1'b0, CW'(0));
        loop_bit("dbpsk4", 1'b1, 1'b1, CW'(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
